// File: rtl/aes_block_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : aes_block_loader                                                  |
// | Frames an 8-bit byte stream into a 128-bit key / ciphertext block for the |
// | decrypt core. Optional macro AES_LOADER_STATS_EN adds blk/err counters.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module aes_block_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_CT         = 8'h43
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] cipher_text,
  output logic [127:0] key,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         key_loaded,
  output logic         err_cmd,
  output logic         err_nokey,
  output logic         err_timeout
`ifdef AES_LOADER_STATS_EN
  ,
  output logic [15:0]  blk_count,
  output logic [15:0]  err_count
`endif
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_KEY   = 2'd1;
  localparam logic [1:0] c_CT    = 2'd2;
  localparam logic [1:0] c_ISSUE = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_next_state;
  logic         r_in_ready;
  // Only 15 bytes are ever held: the 16th is taken straight from in_data on commit.
  logic [119:0] r_shadow;
  logic [3:0]   r_cnt;
  logic [127:0] r_key;
  logic [127:0] r_ct;
  logic         r_blk_valid;
  logic         r_key_loaded;
  logic         r_err_cmd;
  logic         r_err_nokey;
  logic         r_err_tmo;

  logic         w_xfer;
  logic         w_blk_xfer;
  logic         w_in_frame;
  logic         w_last;
  logic         w_tmo_hit;
  logic         w_frame_start;
  logic         w_shift;
  logic         w_key_commit;
  logic         w_ct_commit;
  logic         w_err_cmd;
  logic         w_err_nokey;

  assign w_xfer     = in_valid && r_in_ready;
  assign w_blk_xfer = r_blk_valid && blk_ready;
  assign w_in_frame = (r_state == c_KEY) || (r_state == c_CT);
  assign w_last     = (r_cnt == 4'hF);

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_tmo
      localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
      localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
      logic [c_TMO_W-1:0] r_tmo;

      // Abort fires on the edge where the idle count would reach TIMEOUT_CYCLES.
      assign w_tmo_hit = w_in_frame && !w_xfer && (r_tmo == c_TMO_LAST);

      always_ff @(posedge clk) begin
        if (rst || !w_in_frame || w_xfer || w_tmo_hit) begin
          r_tmo <= '0;
        end else begin
          r_tmo <= r_tmo + c_TMO_W'(1);
        end
      end
    end else begin : g_no_tmo
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_xfer) begin
          if (in_data == CMD_KEY) begin
            w_next_state = c_KEY;
          end else if (in_data == CMD_CT) begin
            w_next_state = c_CT;
          end
        end
      end
      c_KEY: begin
        if ((w_xfer && w_last) || w_tmo_hit) begin
          w_next_state = c_IDLE;
        end
      end
      c_CT: begin
        if (w_xfer && w_last) begin
          w_next_state = r_key_loaded ? c_ISSUE : c_IDLE;
        end else if (w_tmo_hit) begin
          w_next_state = c_IDLE;
        end
      end
      c_ISSUE: begin
        if (w_blk_xfer) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_err_cmd     = 1'b0;
    w_frame_start = 1'b0;
    w_shift       = 1'b0;
    w_key_commit  = 1'b0;
    w_ct_commit   = 1'b0;
    w_err_nokey   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_xfer) begin
          if ((in_data == CMD_KEY) || (in_data == CMD_CT)) begin
            w_frame_start = 1'b1;
          end else begin
            w_err_cmd = 1'b1;
          end
        end
      end
      c_KEY: begin
        w_shift      = w_xfer;
        w_key_commit = w_xfer && w_last;
      end
      c_CT: begin
        w_shift     = w_xfer;
        w_ct_commit = w_xfer && w_last && r_key_loaded;
        w_err_nokey = w_xfer && w_last && !r_key_loaded;
      end
      default: begin
        w_shift = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready   <= 1'b0;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_key        <= '0;
      r_ct         <= '0;
      r_blk_valid  <= 1'b0;
      r_key_loaded <= 1'b0;
      r_err_cmd    <= 1'b0;
      r_err_nokey  <= 1'b0;
      r_err_tmo    <= 1'b0;
    end else begin
      r_in_ready <= (w_next_state != c_ISSUE);

      if (w_frame_start || w_tmo_hit) begin
        r_shadow <= '0;
        r_cnt    <= '0;
      end else if (w_shift) begin
        r_shadow <= {r_shadow[111:0], in_data};
        r_cnt    <= r_cnt + 4'd1;
      end

      if (w_key_commit) begin
        r_key        <= {r_shadow, in_data};
        r_key_loaded <= 1'b1;
      end

      if (w_ct_commit) begin
        r_ct        <= {r_shadow, in_data};
        r_blk_valid <= 1'b1;
      end else if (w_blk_xfer) begin
        r_blk_valid <= 1'b0;
      end

      r_err_cmd   <= w_err_cmd;
      r_err_nokey <= w_err_nokey;
      r_err_tmo   <= w_tmo_hit;
    end
  end

`ifdef AES_LOADER_STATS_EN
  logic [15:0] r_blk_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_blk_xfer && (r_blk_count != 16'hFFFF)) begin
        r_blk_count <= r_blk_count + 16'd1;
      end
      if ((w_err_cmd || w_err_nokey || w_tmo_hit) && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign blk_count = r_blk_count;
  assign err_count = r_err_count;
`endif

  assign in_ready    = r_in_ready;
  assign cipher_text = r_ct;
  assign key         = r_key;
  assign blk_valid   = r_blk_valid;
  assign key_loaded  = r_key_loaded;
  assign err_cmd     = r_err_cmd;
  assign err_nokey   = r_err_nokey;
  assign err_timeout = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_loader.sv
`default_nettype none
// Testbench for aes_block_loader: directed FIPS-197 vectors plus randomized
// key/ciphertext frames checked against a byte-level reference model.
module tb_aes_block_loader;

  localparam int         T       = 20;
  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_CT  = 8'h43;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] cipher_text;
  logic [127:0] key;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic         key_loaded;
  logic         err_cmd;
  logic         err_nokey;
  logic         err_timeout;
`ifdef AES_LOADER_STATS_EN
  logic [15:0]  blk_count;
  logic [15:0]  err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [127:0] m_key = '0;
  logic         m_key_loaded = 1'b0;

  aes_block_loader #(
    .TIMEOUT_CYCLES(T),
    .CMD_KEY       (CMD_KEY),
    .CMD_CT        (CMD_CT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cipher_text(cipher_text),
    .key        (key),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .key_loaded (key_loaded),
    .err_cmd    (err_cmd),
    .err_nokey  (err_nokey),
    .err_timeout(err_timeout)
`ifdef AES_LOADER_STATS_EN
    ,
    .blk_count  (blk_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drives one byte; returns 1 time unit after the edge on which it transferred.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte: in_ready observed %b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Payload byte i (first sent = 0) occupies bits [127-8i -: 8].
  task automatic send_frame(input logic [7:0] hdr, input logic [127:0] payload);
    send_byte(hdr);
    for (int i = 0; i < 16; i++) begin
      send_byte(payload[127-8*i -: 8]);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [127:0] k);
    send_frame(CMD_KEY, k);
    m_key        = k;
    m_key_loaded = 1'b1;
    chk("key_commit", key, m_key);
    chk1("key_loaded", key_loaded, 1'b1);
    chk1("no_blk_on_key", blk_valid, 1'b0);
  endtask

  task automatic issue_block(input logic [127:0] ct, input int hold);
    send_frame(CMD_CT, ct);
    chk1("blk_valid_rise", blk_valid, 1'b1);
    chk("ct_issue", cipher_text, ct);
    chk("key_at_issue", key, m_key);
    chk1("in_ready_issue", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk1("blk_valid_hold", blk_valid, 1'b1);
      chk("ct_hold", cipher_text, ct);
      chk1("in_ready_hold", in_ready, 1'b0);
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    chk1("blk_valid_drop", blk_valid, 1'b0);
    chk1("in_ready_after_blk", in_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_key        = '0;
    m_key_loaded = 1'b0;
  endtask

  initial begin
    logic [127:0] k;
    logic [127:0] ct;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk("rst_key", key, '0);
    chk("rst_ct", cipher_text, '0);
    chk1("rst_blk_valid", blk_valid, 1'b0);
    chk1("rst_key_loaded", key_loaded, 1'b0);
    chk1("rst_err_cmd", err_cmd, 1'b0);
    chk1("rst_err_nokey", err_nokey, 1'b0);
    chk1("rst_err_timeout", err_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("in_ready_after_rst", in_ready, 1'b1);

    // FIPS-197 key and ciphertext, core stalls 5 cycles
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    issue_block(128'h3925841d02dc09fbdc118597196a0b32, 5);

    // Randomized frames; header values planted as payload bytes
    for (int it = 0; it < 3; it++) begin
      k = rand128();
      k[127-8*3 -: 8] = CMD_CT;
      k[127-8*9 -: 8] = CMD_KEY;
      load_key(k);
      ct = rand128();
      ct[127-8*15 -: 8] = CMD_KEY;
      issue_block(ct, int'($urandom_range(0, 3)));
    end

    // blk_ready asserted with nothing pending is ignored
    @(negedge clk);
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    blk_ready = 1'b0;
    chk1("idle_blk_ready_ignored", blk_valid, 1'b0);

    // Unknown header
    send_byte(8'h55);
    chk1("err_cmd_pulse", err_cmd, 1'b1);
    chk1("err_cmd_excl_tmo", err_timeout, 1'b0);
    @(posedge clk);
    #1;
    chk1("err_cmd_one_cycle", err_cmd, 1'b0);

    // Partial key frame, then T idle cycles
    send_byte(CMD_KEY);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    for (int c = 1; c <= T; c++) begin
      @(posedge clk);
      #1;
      chk1("err_timeout_window", err_timeout, (c == T));
    end
    @(posedge clk);
    #1;
    chk1("err_timeout_one_cycle", err_timeout, 1'b0);
    chk("key_kept_after_tmo", key, m_key);
    chk1("in_ready_after_tmo", in_ready, 1'b1);
    // A fresh frame after the abort must need all 16 payload bytes again
    load_key(rand128());

    // Reset while a block is pending
    send_frame(CMD_CT, rand128());
    chk1("issue_before_rst", blk_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_issue_blk_valid", blk_valid, 1'b0);
    chk("rst_issue_key", key, '0);
    chk1("rst_issue_key_loaded", key_loaded, 1'b0);
    chk1("rst_issue_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk1("rst_hold_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_key = '0;
    m_key_loaded = 1'b0;
    @(posedge clk);
    #1;
    chk1("rst_release_in_ready", in_ready, 1'b1);

    // Ciphertext with no key
    send_frame(CMD_CT, rand128());
    chk1("err_nokey_pulse", err_nokey, 1'b1);
    chk1("nokey_no_blk", blk_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("err_nokey_one_cycle", err_nokey, 1'b0);
    chk1("nokey_still_no_blk", blk_valid, 1'b0);
    chk1("nokey_in_ready", in_ready, 1'b1);
    load_key(rand128());

`ifdef AES_LOADER_STATS_EN
    do_reset();
    load_key(rand128());
    for (int b = 0; b < 3; b++) issue_block(rand128(), 0);
    send_byte(8'h00);
    send_byte(8'hFF);
    @(posedge clk);
    #1;
    chk("blk_count", 128'(blk_count), 128'd3);
    chk("err_count", 128'(err_count), 128'd2);
    do_reset();
    chk("blk_count_rst", 128'(blk_count), 128'd0);
    chk("err_count_rst", 128'(err_count), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
